// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for one port of the byte-addressable 32-bit SRAM.
// Sequences loads, word stores and read-modify-write sub-word stores.
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PROT_LIMIT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] PROT_ADDR = ADDR_WIDTH'(PROT_LIMIT);

  state_t state, next_state;

  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [15:0] sub_wdata;
  logic        accept;
  logic        req_err;
  logic        word_store;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept     = req_valid && req_ready;
  assign req_err    = (req_size == 2'b11) || (req_we && (req_addr < PROT_ADDR));
  assign word_store = req_we && (req_size == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)         next_state = RESP;
          else if (word_store) next_state = WR;
          else                 next_state = RD;
        end
      end
      RD:      next_state = CAP;
      CAP:     next_state = we_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // mem_we is gated by rst so a reset landing on WR suppresses the write.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    mem_we     = (state == WR) && !rst;
    resp_valid = (state == RESP);
  end

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, mem_rdata[7:0]}
                                : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, mem_rdata[15:0]}
                                : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // mem_addr doubles as the latched request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      sub_wdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            sub_wdata <= req_wdata[15:0];
            mem_addr  <= req_addr;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (word_store) begin
              mem_wdata <= req_wdata;
            end
          end
        end
        CAP: begin
          if (we_q) begin
            if (size_q == 2'b00) mem_wdata <= {mem_rdata[31:8], sub_wdata[7:0]};
            else                 mem_wdata <= {mem_rdata[31:16], sub_wdata};
          end else begin
            resp_rdata <= load_ext;
            resp_err   <= 1'b0;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: behavioural byte SRAM plus a
// reference memory model feeding an expected-response scoreboard.
module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;

  sram_port_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_LIMIT(1000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   last_we_cyc = 0;

  logic [7:0] sram    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) cyc++;

  // Little-endian byte SRAM with a one-cycle registered read.
  always @(posedge clk) begin
    logic [31:0] q;
    q = '0;
    if (!$isunknown(mem_addr)) begin
      for (int i = 0; i < 4; i++) q[8*i +: 8] = sram_rd(mem_addr + 32'(i));
      if (mem_we === 1'b1)
        for (int i = 0; i < 4; i++) sram[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
    end
    mem_rdata <= q;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      last_we_cyc = cyc;
    end
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (resp_rdata !== mon_e.rdata) begin
          failures++;
          $display("[TB] FAIL resp_rdata: got %h, required %h", resp_rdata, mon_e.rdata);
        end
        checks++;
        if (resp_err !== mon_e.err) begin
          failures++;
          $display("[TB] FAIL resp_err: got %b, required %b", resp_err, mon_e.err);
        end
        checks++;
        if (cyc - mon_e.acc_cyc !== mon_e.lat) begin
          failures++;
          $display("[TB] FAIL latency: got %0d, required %0d", cyc - mon_e.acc_cyc, mon_e.lat);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit expect_resp, output int acc);
    int t;
    exp_t e;
    logic [31:0] w;
    int nb;
    t = 0;
    acc = -1;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
      return;
    end
    acc = cyc;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    if (expect_resp) begin
      e.acc_cyc = acc;
      e.rdata   = '0;
      e.err     = (size == 2'b11) || (we && addr < 32'd1000);
      if (e.err) begin
        e.lat = 1;
      end else if (we) begin
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        e.lat = (size == 2'b10) ? 2 : 4;
      end else begin
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_rd(addr + 32'(i));
        if (size == 2'b00)
          e.rdata = uns ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        else if (size == 2'b01)
          e.rdata = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        else
          e.rdata = w;
        e.lat = 3;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL resp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int acc;
    issue(we, size, uns, addr, wdata, 1'b1, acc);
    wait_resp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b, required 0", req_ready); end
    checks++;
    if ({resp_valid, resp_err, mem_we} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_ctrl: got %b, required 000", {resp_valid, resp_err, mem_we});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      failures++; $display("[TB] FAIL reset_data: got %h %h %h, required zeros", resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_word();
    req(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF);
    req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0);
  endtask

  task automatic test_byte_store();
    int acc;
    int n0;
    req(1'b1, 2'b10, 1'b0, 32'h3000, 32'h11223344);
    n0 = we_count;
    issue(1'b1, 2'b00, 1'b0, 32'h3000, 32'h000000AB, 1'b1, acc);
    wait_resp();
    checks++;
    if (we_count - n0 !== 1) begin
      failures++; $display("[TB] FAIL rmw_we_count: got %0d, required 1", we_count - n0);
    end
    checks++;
    if (last_we_cyc - acc !== 3) begin
      failures++; $display("[TB] FAIL rmw_we_time: got %0d, required 3", last_we_cyc - acc);
    end
    req(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
    req(1'b1, 2'b01, 1'b0, 32'h3002, 32'h0000BEEF);
    req(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
  endtask

  task automatic test_extension();
    req(1'b1, 2'b10, 1'b0, 32'h3000, 32'h800100F0);
    req(1'b0, 2'b00, 1'b0, 32'h3000, 32'h0);
    req(1'b0, 2'b00, 1'b1, 32'h3000, 32'h0);
    req(1'b0, 2'b01, 1'b0, 32'h3002, 32'h0);
    req(1'b0, 2'b01, 1'b1, 32'h3002, 32'h0);
  endtask

  task automatic test_protection();
    int n0;
    n0 = we_count;
    req(1'b1, 2'b10, 1'b0, 32'd999, 32'h12345678);
    req(1'b1, 2'b00, 1'b0, 32'd999, 32'h0000005A);
    req(1'b1, 2'b11, 1'b0, 32'h5000, 32'h0);
    req(1'b0, 2'b11, 1'b0, 32'h5000, 32'h0);
    checks++;
    if (we_count !== n0) begin
      failures++; $display("[TB] FAIL err_no_write: got %0d writes, required 0", we_count - n0);
    end
    req(1'b1, 2'b10, 1'b0, 32'd1000, 32'hCAFEF00D);
    req(1'b0, 2'b10, 1'b0, 32'd1000, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    req(1'b0, 2'b00, 1'b0, 32'd999, 32'h0);
  endtask

  task automatic test_unaligned();
    req(1'b1, 2'b10, 1'b0, 32'h4001, 32'h0A0B0C0D);
    req(1'b0, 2'b00, 1'b1, 32'h4001, 32'h0);
    req(1'b0, 2'b00, 1'b1, 32'h4004, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h4001, 32'h0);
    req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h89ABCDEF);
    req(1'b0, 2'b01, 1'b1, 32'h00000000, 32'h0);
  endtask

  task automatic test_back_to_back();
    int a0;
    int a1;
    issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 1'b1, a0);
    wait_resp();
    issue(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 1'b1, a1);
    wait_resp();
    checks++;
    if (a1 - a0 !== 4) begin
      failures++; $display("[TB] FAIL back_to_back_gap: got %0d, required 4", a1 - a0);
    end
    for (int k = 0; k < 24; k++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 4) == 0) ? 32'(990 + $urandom_range(0, 20))
                                         : 32'(32'h6000 + $urandom_range(0, 7));
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          addr, $urandom);
    end
  endtask

  task automatic test_reset_in_wr();
    int acc;
    issue(1'b1, 2'b00, 1'b0, 32'h3000, 32'h00000055, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_we: got %b, required 0", mem_we); end
    @(negedge clk);
    checks++;
    if ({resp_valid, mem_we, mem_addr} !== 34'd0) begin
      failures++; $display("[TB] FAIL rst_outputs: got %b %b %h, required 0 0 0", resp_valid, mem_we, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready: got %b, required 1", req_ready); end
    req(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_extension();
    test_protection();
    test_unaligned();
    test_back_to_back();
    test_reset_in_wr();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
Initiator-side controller for one port of the team's dual-port, byte-addressable, little-endian 32-bit SRAM.
- Accepts byte, halfword and word load/store requests from a core via a valid/ready handshake.
- Sequences the SRAM's synchronous read/write port, doing read-modify-write for sub-word stores.
- Returns load data with sign or zero extension.
- Enforces the write-protected low region.

Parameters:
- ADDR_WIDTH, 32, byte address width; matches the SRAM.
- DATA_WIDTH, 32, word width; only 32 is supported.
- PROT_LIMIT, 1000, writes to byte addresses below this value are rejected.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address; any alignment is legal.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: request rejected.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_wdata  out  DATA_WIDTH  to SRAM data.
- mem_we  out  1  to SRAM we.
- mem_rdata  in  DATA_WIDTH  from SRAM q; valid the cycle after mem_addr is presented.

Behaviour:
- Reset values: state IDLE; resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
- req_ready = 1 only in IDLE with rst low.
- Acceptance cycle (C0) = the cycle where req_valid && req_ready. addr, we, size, unsigned and wdata are latched at the end of C0.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE transitions:
  - to RESP with err if req_size = 11, or if req_we and req_addr < PROT_LIMIT;
  - to WR for a word store, with mem_wdata = req_wdata;
  - otherwise to RD.
- Loads below PROT_LIMIT are legal.
- RD: mem_addr = latched addr, mem_we = 0. The SRAM registers q at the end of RD. Next state CAP.
- CAP: mem_rdata is valid.
  - Load: resp_rdata is registered from mem_rdata. Byte uses [7:0] and half uses [15:0], extended per unsigned; word is taken as-is. Next state RESP.
  - Sub-word store: mem_wdata is registered as the merge: byte gives {rdata[31:8], wdata[7:0]}; half gives {rdata[31:16], wdata[15:0]}. Next state WR.
- WR: mem_addr = latched addr; mem_we = 1 AND NOT rst. Asserting rst during WR suppresses the write. Next state RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response back-pressure. The next request can be accepted in the cycle after RESP.
- Latency from C0 to the resp_valid cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- mem_we is 0 in every state except WR. An error request never asserts mem_we.
- resp_rdata and resp_err hold their values until the next RESP. Both are cleared to 0 on entry to RESP for stores; resp_err is set only for errors.
- Address arithmetic is modulo 2^ADDR_WIDTH. Accesses within 3 bytes of the top wrap in the SRAM; the controller does not check for this. The protection check uses only the base address.
- A store at PROT_LIMIT-1 is rejected; a store at PROT_LIMIT is accepted.
- Reset in any state returns to IDLE next cycle with all outputs at reset values. An in-flight request is dropped with no response.
- The SRAM is read-after-write coherent. A load issued right after a store to the same address returns the new data.

Test Plan:
- Store word 0xDEADBEEF to 0x2000, then load word from 0x2000 -> resp_rdata 0xDEADBEEF. Load resp_valid comes 3 cycles after acceptance; store resp_valid comes 2 cycles after acceptance.
- Pre-store word 0x11223344 at 0x3000, store byte 0xAB to 0x3000 -> word reads 0x112233AB. mem_we is high for exactly 1 cycle, 3 cycles after acceptance.
- Load byte from 0x3000 holding 0x...F0 with unsigned=0 -> 0xFFFFFFF0; with unsigned=1 -> 0x000000F0. Load half 0x8001 signed -> 0xFFFF8001.
- Store word to 999 -> resp_err=1 one cycle after acceptance, mem_we never high. Store to 1000 -> resp_err=0. Load from 4 -> resp_err=0. req_size=11 -> resp_err=1.
- Unaligned store word 0x0A0B0C0D to 0x4001, then load byte from 0x4001 -> 0x0D, and load byte from 0x4004 -> 0x0A.
- Assert rst during the WR cycle of a byte store -> mem_we stays 0, memory is unchanged, no resp_valid, and req_ready=1 the cycle after reset is released.
